serial_sub_ctrl: RTL and testbench

- Bit-serial multi-bit subtractor controller; computes a - b - bin over WIDTH bits.
- Time-shares one internal full-subtractor bit cell: diff = a^b^c, borrow = (~a&b) | (~(a^b)&c).
- Sequences the cell LSB-first, one bit per clock, with a start/done handshake.
- Sits between a requesting master and the subtractor cell; replaces a WIDTH-wide combinational subtractor with one bit cell plus a counter.

---
 rtl/serial_sub_ctrl.sv | 121 ++++++++++++
 tb/tb_serial_sub_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl
//   Bit-serial subtractor controller. It computes a - b - bin over WIDTH bits
//   with a single full-subtractor bit cell, one bit per clock, LSB first.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      synchronous active-low reset
//     start      request, sampled only while idle
//     a, b, bin  minuend, subtrahend and borrow-in, latched on the accepting edge
//     busy       high while running and during the done cycle
//     done       one-cycle completion pulse
//     diff       result a-b-bin mod 2**WIDTH, held until the next completion
//     borrow_out final borrow out of the MSB cell (1 iff a < b+bin)
//
//   state  | meaning
//   IDLE   | waiting for start
//   RUN    | one bit cell evaluation per clock, WIDTH clocks
//   DONE   | result published, done high for this one cycle
module serial_sub_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             brw_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    logic             cell_diff_d;
    logic             cell_brw_d;
    logic [WIDTH-1:0] res_d;

    // Shared full-subtractor cell on the operand LSBs; its diff bit enters the
    // result register at the MSB so that after WIDTH shifts bit 0 sits at bit 0.
    always_comb begin
        cell_diff_d = a_q[0] ^ b_q[0] ^ brw_q;
        cell_brw_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
        res_d       = {cell_diff_d, res_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        brw_q   <= bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    brw_q <= cell_brw_d;
                    res_q <= res_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        diff_q  <= res_d;
                        bout_q  <= cell_brw_d;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                // Unused encoding: return to idle, leave outputs untouched.
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;

    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       bin2;
    logic       busy2;
    logic       done2;
    logic [1:0] diff2;
    logic       borrow_out2;

    int tests = 0;
    int fails = 0;

    logic [7:0] prev_diff;
    logic       prev_bout;

    serial_sub_ctrl #(.WIDTH(8), .CW(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
    );

    serial_sub_ctrl #(.WIDTH(2), .CW(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .bin(bin2),
        .busy(busy2), .done(done2), .diff(diff2), .borrow_out(borrow_out2)
    );

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation on the 8-bit instance with cycle-by-cycle checks.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                          input logic [7:0] exp_diff, input logic exp_bout, input string tag);
        a = av; b = bv; bin = bi; start = 1'b1;
        tick();  // E0
        check({tag, " E0 busy"}, 32'(busy), 32'd1);
        check({tag, " E0 done"}, 32'(done), 32'd0);
        check({tag, " E0 diff hold"}, 32'(diff), 32'(prev_diff));
        start = 1'b0; a = ~av; b = ~bv; bin = ~bi;
        for (int i = 1; i < 8; i++) begin
            tick();
            check({tag, " run busy"}, 32'(busy), 32'd1);
            check({tag, " run done"}, 32'(done), 32'd0);
            check({tag, " run diff hold"}, 32'(diff), 32'(prev_diff));
            check({tag, " run bout hold"}, 32'(borrow_out), 32'(prev_bout));
        end
        tick();  // E8
        check({tag, " E8 done"}, 32'(done), 32'd1);
        check({tag, " E8 busy"}, 32'(busy), 32'd1);
        check({tag, " diff"}, 32'(diff), 32'(exp_diff));
        check({tag, " borrow_out"}, 32'(borrow_out), 32'(exp_bout));
        tick();  // E9
        check({tag, " E9 done"}, 32'(done), 32'd0);
        check({tag, " E9 busy"}, 32'(busy), 32'd0);
        check({tag, " E9 diff"}, 32'(diff), 32'(exp_diff));
        prev_diff = exp_diff;
        prev_bout = exp_bout;
    endtask

    initial begin
        logic [2:0] ref3;
        logic [4:0] combo;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
        tick();
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset diff", 32'(diff), 32'd0);
        check("reset borrow_out", 32'(borrow_out), 32'd0);
        check("reset busy2", 32'(busy2), 32'd0);
        rst_n = 1'b1;
        prev_diff = 8'd0;
        prev_bout = 1'b0;
        tick();
        check("idle busy", 32'(busy), 32'd0);

        run_op(8'd100, 8'd37, 1'b0, 8'd63, 1'b0, "100-37");
        run_op(8'd5, 8'd9, 1'b0, 8'hFC, 1'b1, "5-9");
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "FF-FF-1");
        run_op(8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, "80-0-1");

        // start while busy is ignored
        a = 8'd50; b = 8'd20; bin = 1'b0; start = 1'b1;
        tick();  // E0
        check("ign E0 busy", 32'(busy), 32'd1);
        start = 1'b0; a = 8'd200; b = 8'd1;
        tick(); tick();  // E1, E2
        start = 1'b1;
        tick();  // E3
        start = 1'b0;
        check("ign E3 busy", 32'(busy), 32'd1);
        check("ign E3 done", 32'(done), 32'd0);
        for (int i = 4; i < 8; i++) begin
            tick();
            check("ign run done", 32'(done), 32'd0);
        end
        start = 1'b1;
        tick();  // E8
        start = 1'b0;
        check("ign E8 done", 32'(done), 32'd1);
        check("ign diff", 32'(diff), 32'd30);
        check("ign borrow_out", 32'(borrow_out), 32'd0);
        check("ign E8 busy", 32'(busy), 32'd1);
        tick();  // E9
        check("ign E9 busy", 32'(busy), 32'd0);
        check("ign E9 done", 32'(done), 32'd0);
        tick();
        tick();
        check("ign no extra done", 32'(done), 32'd0);
        check("ign stays idle", 32'(busy), 32'd0);
        prev_diff = 8'd30;
        prev_bout = 1'b0;

        // reset mid-run discards the operation and clears the outputs
        a = 8'd10; b = 8'd3; bin = 1'b0; start = 1'b1;
        tick();  // E0
        start = 1'b0;
        tick(); tick(); tick();  // E1..E3
        check("rst pre busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();  // E4
        rst_n = 1'b1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst diff", 32'(diff), 32'd0);
        check("rst borrow_out", 32'(borrow_out), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rst no late done", 32'(done), 32'd0);
        end
        prev_diff = 8'd0;
        prev_bout = 1'b0;
        run_op(8'd7, 8'd2, 1'b0, 8'd5, 1'b0, "7-2");

        // WIDTH=2: all {a,b,bin} with start held high, one op per 4 cycles
        combo = 5'd0;
        {a2, b2, bin2} = combo;
        start2 = 1'b1;
        for (int k = 0; k < 32; k++) begin
            ref3 = {1'b0, a2} - {1'b0, b2} - {2'b00, bin2};
            tick();  // accept
            check("w2 accept busy", 32'(busy2), 32'd1);
            combo = 5'(k + 1);
            {a2, b2, bin2} = combo;
            tick();
            check("w2 E1 done", 32'(done2), 32'd0);
            tick();
            check("w2 done", 32'(done2), 32'd1);
            check("w2 result", 32'({borrow_out2, diff2}), 32'(ref3));
            tick();
            check("w2 idle busy", 32'(busy2), 32'd0);
            check("w2 idle done", 32'(done2), 32'd0);
        end
        start2 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
